simd_lane_adder: RTL

Pipelined, parametrised SIMD adder/subtractor: a `LANES`×`LANE_W`-bit datapath whose lane boundaries are individually linked (carry passes) or broken (independent lanes) per transaction. It generalises the team's fixed 16-bit two-half split adder to arbitrary lane count and width, adds subtraction and per-lane carry-out, and registers one lane per stage so wide words close timing. It sits between the operand register file and the writeback mux, with valid/ready flow control on both sides.

---
 rtl/simd_adder_pkg.sv | 12 +
 rtl/lane_adder_stage.sv | 96 +++++++++
 rtl/simd_lane_adder.sv | 111 +++++++++++
 3 files changed

// File: rtl/simd_adder_pkg.sv
// Shared constants and helpers for the SIMD lane adder and its per-lane pipeline stages.
// No logic, so no latency; backpressure lives entirely in the top-level advance signal.
package simd_adder_pkg;

  localparam int unsigned LANE_W_DEF = 8;
  localparam int unsigned LANES_DEF  = 4;

  function automatic int unsigned lane_lsb(input int unsigned lane, input int unsigned lane_w);
    return lane * lane_w;
  endfunction

endpackage

// File: rtl/lane_adder_stage.sv
// One lane of the SIMD adder: carry-select add of lane LANE plus the stage register for the whole beat.
// Latency 1 cycle; holds all state while en_i is low.
module lane_adder_stage
  import simd_adder_pkg::*;
#(
  parameter  int unsigned LANE_W = LANE_W_DEF,
  parameter  int unsigned LANES  = LANES_DEF,
  parameter  int unsigned LANE   = 0,
  localparam int unsigned W      = LANES * LANE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             vld_i,
  input  logic             sub_i,
  input  logic [LANES-2:0] link_i,
  input  logic             cin_i,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  input  logic [W-1:0]     sum_i,
  input  logic [LANES-1:0] co_i,
  output logic             vld_o,
  output logic             sub_o,
  output logic [LANES-2:0] link_o,
  output logic             carry_o,
  output logic [W-1:0]     a_o,
  output logic [W-1:0]     b_o,
  output logic [W-1:0]     sum_o,
  output logic [LANES-1:0] co_o
);

  localparam int unsigned LSB = lane_lsb(LANE, LANE_W);

  logic [LANE_W-1:0] a_l, b_l, s0, s1, lane_sum;
  logic              c0, c1, lane_co;
  logic [W-1:0]      sum_d;
  logic [LANES-1:0]  co_d;

  logic              vld_q, sub_q, carry_q;
  logic [LANES-2:0]  link_q;
  logic [W-1:0]      a_q, b_q, sum_q;
  logic [LANES-1:0]  co_q;

  assign a_l = a_i[LSB +: LANE_W];
  assign b_l = b_i[LSB +: LANE_W] ^ {LANE_W{sub_i}};

  // Both carry-in outcomes are formed up front so the late-arriving carry only drives a mux.
  assign {c0, s0} = {1'b0, a_l} + {1'b0, b_l};
  assign {c1, s1} = {1'b0, a_l} + {1'b0, b_l} + {{LANE_W{1'b0}}, 1'b1};

  assign lane_sum = cin_i ? s1 : s0;
  assign lane_co  = cin_i ? c1 : c0;

  always_comb begin
    sum_d                 = sum_i;
    sum_d[LSB +: LANE_W]  = lane_sum;
    co_d                  = co_i;
    co_d[LANE]            = lane_co;
  end

  // The slots this lane overwrites arrive as don't-care from upstream.
  logic unused_slot;
  assign unused_slot = ^{sum_i[LSB +: LANE_W], co_i[LANE]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q   <= 1'b0;
      sub_q   <= 1'b0;
      link_q  <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      co_q    <= '0;
    end else if (en_i) begin
      vld_q   <= vld_i;
      sub_q   <= sub_i;
      link_q  <= link_i;
      carry_q <= lane_co;
      a_q     <= a_i;
      b_q     <= b_i;
      sum_q   <= sum_d;
      co_q    <= co_d;
    end
  end

  assign vld_o   = vld_q;
  assign sub_o   = sub_q;
  assign link_o  = link_q;
  assign carry_o = carry_q;
  assign a_o     = a_q;
  assign b_o     = b_q;
  assign sum_o   = sum_q;
  assign co_o    = co_q;

endmodule

// File: rtl/simd_lane_adder.sv
// LANES x LANE_W SIMD add/subtract with per-boundary carry linking, one lane per pipeline stage.
// Latency LANES cycles, one beat per cycle; whole pipe stalls when the output is held (in_ready = advance).
module simd_lane_adder
  import simd_adder_pkg::*;
#(
  parameter  int unsigned LANE_W = LANE_W_DEF,
  parameter  int unsigned LANES  = LANES_DEF,
  localparam int unsigned W      = LANES * LANE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic             ci,
  input  logic             sub,
  input  logic [LANES-2:0] link,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     sum,
  output logic [LANES-1:0] co
);

  typedef struct packed {
    logic             vld;
    logic             sub;
    logic [LANES-2:0] link;
    logic             carry;
    logic [W-1:0]     sum;
    logic [LANES-1:0] co;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
  } stage_t;

  stage_t st [LANES];
  logic   advance;

  assign out_valid = st[LANES-1].vld;
  assign sum       = st[LANES-1].sum;
  assign co        = st[LANES-1].co;
  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance && !rst;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic             vld_in, sub_in, cin_in;
    logic [LANES-2:0] link_in;
    logic [W-1:0]     a_in, b_in, sum_in;
    logic [LANES-1:0] co_in;

    logic             vld_w, sub_w, carry_w;
    logic [LANES-2:0] link_w;
    logic [W-1:0]     a_w, b_w, sum_w;
    logic [LANES-1:0] co_w;

    if (k == 0) begin : g_head
      assign vld_in  = in_valid;
      assign sub_in  = sub;
      assign link_in = link;
      assign cin_in  = ci ^ sub;
      assign a_in    = a;
      assign b_in    = b;
      assign sum_in  = '0;
      assign co_in   = '0;
    end else begin : g_body
      // A broken boundary restarts the segment: carry 0 for add, no-borrow (1) for subtract.
      assign vld_in  = st[k-1].vld;
      assign sub_in  = st[k-1].sub;
      assign link_in = st[k-1].link;
      assign cin_in  = st[k-1].link[k-1] ? st[k-1].carry : st[k-1].sub;
      assign a_in    = st[k-1].a;
      assign b_in    = st[k-1].b;
      assign sum_in  = st[k-1].sum;
      assign co_in   = st[k-1].co;
    end

    lane_adder_stage #(
      .LANE_W (LANE_W),
      .LANES  (LANES),
      .LANE   (k)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en_i    (advance),
      .vld_i   (vld_in),
      .sub_i   (sub_in),
      .link_i  (link_in),
      .cin_i   (cin_in),
      .a_i     (a_in),
      .b_i     (b_in),
      .sum_i   (sum_in),
      .co_i    (co_in),
      .vld_o   (vld_w),
      .sub_o   (sub_w),
      .link_o  (link_w),
      .carry_o (carry_w),
      .a_o     (a_w),
      .b_o     (b_w),
      .sum_o   (sum_w),
      .co_o    (co_w)
    );

    assign st[k] = {vld_w, sub_w, link_w, carry_w, sum_w, co_w, a_w, b_w};
  end

  // The last stage's forwarding fields have no consumer.
  logic unused_tail;
  assign unused_tail = ^{st[LANES-1].sub, st[LANES-1].link, st[LANES-1].carry,
                         st[LANES-1].a, st[LANES-1].b};

endmodule
